// File: rtl/axis_rr_input_arbiter.sv
// Packet-granular round-robin merge of NUM_PORTS AXI4-Stream slaves into one master.
// Handshake: a beat transfers on a clock edge where tvalid and tready are both high; tvalid never waits on tready.
module axis_rr_input_arbiter #(
    parameter int NUM_PORTS    = 5,
    parameter int C_DATA_WIDTH = 256,
    parameter int C_USER_WIDTH = 128
) (
    input  logic                                axis_aclk,
    input  logic                                reset,
    input  logic [NUM_PORTS*C_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_PORTS*C_DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [NUM_PORTS*C_USER_WIDTH-1:0]   s_axis_tuser,
    input  logic [NUM_PORTS-1:0]                s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]                s_axis_tlast,
    output logic [NUM_PORTS-1:0]                s_axis_tready,
    output logic [C_DATA_WIDTH-1:0]             m_axis_tdata,
    output logic [C_DATA_WIDTH/8-1:0]           m_axis_tkeep,
    output logic [C_USER_WIDTH-1:0]             m_axis_tuser,
    output logic                                m_axis_tvalid,
    output logic                                m_axis_tlast,
    input  logic                                m_axis_tready,
    input  logic [NUM_PORTS-1:0]                port_enable,
    input  logic                                cnt_clear,
    output logic [NUM_PORTS*32-1:0]             pkt_cnt,
    output logic [2:0]                          cur_grant
);

    localparam int GW = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;
    localparam int KW = C_DATA_WIDTH / 8;

    typedef enum logic {IDLE, SEND} state_t;

    state_t               state, state_next;
    logic [GW-1:0]        grant, grant_next;
    logic [GW-1:0]        last_grant, last_grant_next;
    logic                 in_pkt, in_pkt_next;
    logic                 eop;
    logic                 sel_valid, sel_last;
    logic [NUM_PORTS-1:0] req;
    logic [31:0]          cnt [NUM_PORTS];

    // First requester after 'base', wrapping, with 'base' itself considered last.
    function automatic logic [GW-1:0] rr_pick(input logic [NUM_PORTS-1:0] r,
                                              input logic [GW-1:0] base);
        logic [GW-1:0] w;
        int            idx;
        w = base;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            idx = (int'(base) + k) % NUM_PORTS;
            if (r[idx]) w = GW'(idx);
        end
        return w;
    endfunction

    assign req          = s_axis_tvalid & port_enable;
    assign sel_valid    = s_axis_tvalid[grant];
    assign sel_last     = s_axis_tlast[grant];
    assign m_axis_tdata = s_axis_tdata[int'(grant)*C_DATA_WIDTH +: C_DATA_WIDTH];
    assign m_axis_tkeep = s_axis_tkeep[int'(grant)*KW +: KW];
    assign m_axis_tuser = s_axis_tuser[int'(grant)*C_USER_WIDTH +: C_USER_WIDTH];
    assign cur_grant    = 3'(grant);

    always_comb begin
        state_next      = state;
        grant_next      = grant;
        last_grant_next = last_grant;
        in_pkt_next     = in_pkt;
        eop             = 1'b0;
        s_axis_tready   = '0;
        m_axis_tvalid   = 1'b0;
        m_axis_tlast    = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    grant_next = rr_pick(req, last_grant);
                    state_next = SEND;
                end
            end
            SEND: begin
                m_axis_tvalid        = sel_valid;
                m_axis_tlast         = sel_last;
                s_axis_tready[grant] = m_axis_tready;
                if (sel_valid && m_axis_tready) begin
                    if (sel_last) begin
                        eop             = 1'b1;
                        in_pkt_next     = 1'b0;
                        last_grant_next = grant;
                        if (|req) grant_next = rr_pick(req, grant);
                        else      state_next = IDLE;
                    end else begin
                        in_pkt_next = 1'b1;
                    end
                end else if (!in_pkt && !sel_valid) begin
                    // Granted port has no packet started: release the grant rather than starve others.
                    if (|req) grant_next = rr_pick(req, grant);
                    else      state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= GW'(NUM_PORTS - 1);
            in_pkt     <= 1'b0;
        end else begin
            state      <= state_next;
            grant      <= grant_next;
            last_grant <= last_grant_next;
            in_pkt     <= in_pkt_next;
        end
    end

    always_ff @(posedge axis_aclk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (reset || cnt_clear)
                cnt[i] <= '0;
            else if (eop && grant == GW'(i))
                cnt[i] <= cnt[i] + 32'd1;
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
        assign pkt_cnt[g*32 +: 32] = cnt[g];
    end

endmodule

// File: tb/tb_axis_rr_input_arbiter.sv
// Directed bench for axis_rr_input_arbiter: cycle table plus packet-level sequences.
module tb_axis_rr_input_arbiter;

    localparam int N  = 5;
    localparam int DW = 32;
    localparam int UW = 16;
    localparam int KW = DW / 8;

    logic              clk;
    logic              reset;
    logic [N*DW-1:0]   s_tdata;
    logic [N*KW-1:0]   s_tkeep;
    logic [N*UW-1:0]   s_tuser;
    logic [N-1:0]      s_tvalid, s_tlast, s_tready;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic [UW-1:0]     m_tuser;
    logic              m_tvalid, m_tlast, m_tready;
    logic [N-1:0]      port_enable;
    logic              cnt_clear;
    logic [N*32-1:0]   pkt_cnt;
    logic [2:0]        cur_grant;

    axis_rr_input_arbiter #(.NUM_PORTS(N), .C_DATA_WIDTH(DW), .C_USER_WIDTH(UW)) dut (
        .axis_aclk(clk), .reset(reset),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
        .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .port_enable(port_enable), .cnt_clear(cnt_clear),
        .pkt_cnt(pkt_cnt), .cur_grant(cur_grant)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        s_tdata     = '0;
        s_tkeep     = '0;
        s_tuser     = '0;
        s_tvalid    = '0;
        s_tlast     = '0;
        m_tready    = 1'b1;
        port_enable = '1;
        cnt_clear   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] cnt_of(input int p);
        return pkt_cnt[p*32 +: 32];
    endfunction

    // packet sources and scoreboard
    int n_pkt [N];
    int plen  [N];
    int start [N];
    int pk    [N];
    int bt    [N];

    logic [DW+UW+KW:0] exp_q[$];

    int cyc, first_hs, bad_ready;

    task automatic clear_src();
        for (int p = 0; p < N; p++) begin
            n_pkt[p] = 0; plen[p] = 1; start[p] = 0; pk[p] = 0; bt[p] = 0;
        end
        exp_q.delete();
    endtask

    function automatic logic [KW-1:0] keep_of(input logic last);
        return last ? 4'h3 : 4'hF;
    endfunction

    task automatic push_pkt(input int p, input int k, input int len);
        logic last;
        for (int b = 0; b < len; b++) begin
            last = (b == len - 1);
            exp_q.push_back({8'(p), 8'(k), keep_of(last), last, 8'(p), 8'(k), 16'(b)});
        end
    endtask

    task automatic run_traffic(input int mode, input logic [N-1:0] en0, input int en_cyc,
                               input logic [N-1:0] en1, input int limit);
        logic [N-1:0]      hs;
        logic              last;
        logic [DW+UW+KW:0] beat;
        cyc = 0; first_hs = -1; bad_ready = 0;
        while (exp_q.size() > 0 && cyc < limit) begin
            @(negedge clk);
            for (int p = 0; p < N; p++) begin
                last = (bt[p] == plen[p] - 1);
                s_tvalid[p]           = (cyc >= start[p]) && (pk[p] < n_pkt[p]);
                s_tlast[p]            = last;
                s_tdata[p*DW +: DW]   = {8'(p), 8'(pk[p]), 16'(bt[p])};
                s_tuser[p*UW +: UW]   = {8'(p), 8'(pk[p])};
                s_tkeep[p*KW +: KW]   = keep_of(last);
            end
            m_tready    = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
            port_enable = (cyc >= en_cyc) ? en1 : en0;
            #1;
            if (m_tvalid && m_tready) begin
                if (first_hs < 0) first_hs = cyc;
                beat = {m_tuser, m_tkeep, m_tlast, m_tdata};
                if (exp_q.size() == 0) check("unexpected_beat", 64'(beat), 64'hDEAD);
                else                   check("beat", 64'(beat), 64'(exp_q.pop_front()));
            end
            if (s_tready[0] && pk[1] < n_pkt[1]) bad_ready++;
            hs = s_tvalid & s_tready;
            @(posedge clk);
            for (int p = 0; p < N; p++) begin
                if (hs[p]) begin
                    if (bt[p] == plen[p] - 1) begin bt[p] = 0; pk[p]++; end
                    else bt[p]++;
                end
            end
            cyc++;
        end
        check("traffic_done", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        idle_inputs();
    endtask

    // cycle table
    typedef struct {
        logic [N-1:0] v, l, en;
        logic         mr, clr;
        logic         e_mv, e_ml;
        logic [N-1:0] e_sr;
        logic [2:0]   e_g;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [N-1:0] v, l, en, input logic mr, clr, emv, eml,
                       input logic [N-1:0] esr, input logic [2:0] eg);
        vec_t r;
        r.v = v; r.l = l; r.en = en; r.mr = mr; r.clr = clr;
        r.e_mv = emv; r.e_ml = eml; r.e_sr = esr; r.e_g = eg;
        tbl.push_back(r);
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        clear_src();

        // reset release, no traffic
        do_reset();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            check("idle_after_reset", {m_tvalid, 5'(s_tready), 1'(pkt_cnt != '0), cur_grant}, 64'd0);
        end

        // single 4-beat packet from port 2
        do_reset(); clear_src();
        n_pkt[2] = 1; plen[2] = 4; push_pkt(2, 0, 4);
        run_traffic(0, 5'b11111, 0, 5'b11111, 50);
        check("p2_latency", 64'(first_hs), 64'd1);
        check("p2_cnt2", 64'(cnt_of(2)), 64'd1);
        check("p2_cnt0", 64'(cnt_of(0)), 64'd0);
        @(negedge clk);
        s_tvalid = 5'b00100;
        #1;
        check("p2_back_idle", {m_tvalid, 5'(s_tready)}, 64'd0);
        @(negedge clk); idle_inputs();

        // four ports, three 2-beat packets each
        do_reset(); clear_src();
        for (int p = 0; p < N; p++) if (p != 2) begin n_pkt[p] = 3; plen[p] = 2; end
        for (int k = 0; k < 3; k++) begin
            push_pkt(0, k, 2); push_pkt(1, k, 2); push_pkt(3, k, 2); push_pkt(4, k, 2);
        end
        run_traffic(0, 5'b11111, 0, 5'b11111, 200);
        check("rr_no_bubble_cycles", 64'(cyc), 64'd25);
        check("rr_cnt", {cnt_of(4)[7:0], cnt_of(3)[7:0], cnt_of(2)[7:0], cnt_of(1)[7:0], cnt_of(0)[7:0]},
              64'h03_03_00_03_03);

        // tready toggling, port 0 must wait for port 1's packet
        do_reset(); clear_src();
        n_pkt[1] = 1; plen[1] = 6; start[1] = 0;
        n_pkt[0] = 1; plen[0] = 2; start[0] = 1;
        push_pkt(1, 0, 6); push_pkt(0, 0, 2);
        run_traffic(1, 5'b11111, 0, 5'b11111, 200);
        check("toggle_no_ready_p0", 64'(bad_ready), 64'd0);

        // port_enable mask, bit 0 set mid-packet
        do_reset(); clear_src();
        n_pkt[1] = 2; plen[1] = 4;
        n_pkt[0] = 1; plen[0] = 4;
        push_pkt(1, 0, 4); push_pkt(0, 0, 4); push_pkt(1, 1, 4);
        run_traffic(0, 5'b11110, 3, 5'b11111, 200);
        check("mask_cnt0", 64'(cnt_of(0)), 64'd1);
        check("mask_cnt1", 64'(cnt_of(1)), 64'd2);

        // cycle table: single beats, same-port back-to-back, gaps, clear with tlast, mask at arbitration
        do_reset(); clear_src();
        add(5'b00000, 5'b00000, 5'b11111, 1, 0, 0, 0, 5'b00000, 3'd0);
        add(5'b01000, 5'b01000, 5'b11111, 1, 0, 0, 0, 5'b00000, 3'd0);
        add(5'b01000, 5'b01000, 5'b11111, 1, 0, 1, 1, 5'b01000, 3'd3);
        add(5'b01001, 5'b01001, 5'b11111, 1, 0, 1, 1, 5'b01000, 3'd3);
        add(5'b00001, 5'b00000, 5'b11111, 0, 0, 1, 0, 5'b00000, 3'd0);
        add(5'b00001, 5'b00000, 5'b11111, 1, 0, 1, 0, 5'b00001, 3'd0);
        add(5'b00000, 5'b00000, 5'b11111, 1, 0, 0, 0, 5'b00001, 3'd0);
        add(5'b00011, 5'b00001, 5'b11111, 1, 0, 1, 1, 5'b00001, 3'd0);
        add(5'b00010, 5'b00010, 5'b11111, 1, 1, 1, 1, 5'b00010, 3'd1);
        add(5'b00000, 5'b00000, 5'b11111, 1, 0, 0, 0, 5'b00010, 3'd1);
        add(5'b00100, 5'b00100, 5'b11111, 1, 0, 0, 0, 5'b00000, 3'd1);
        add(5'b00100, 5'b00100, 5'b11111, 1, 0, 1, 1, 5'b00100, 3'd2);
        add(5'b10000, 5'b10000, 5'b01111, 1, 0, 0, 0, 5'b00100, 3'd2);
        add(5'b10000, 5'b10000, 5'b01111, 1, 0, 0, 0, 5'b00000, 3'd2);
        add(5'b10000, 5'b00000, 5'b11111, 1, 0, 0, 0, 5'b00000, 3'd2);
        add(5'b10000, 5'b10000, 5'b11111, 1, 0, 1, 1, 5'b10000, 3'd4);
        add(5'b00000, 5'b00000, 5'b11111, 1, 0, 0, 0, 5'b10000, 3'd4);
        add(5'b00000, 5'b00000, 5'b11111, 1, 0, 0, 0, 5'b00000, 3'd4);
        for (int p = 0; p < N; p++) begin
            s_tdata[p*DW +: DW] = 32'hD000_0000 + 32'(p);
            s_tuser[p*UW +: UW] = 16'h5500 + 16'(p);
            s_tkeep[p*KW +: KW] = 4'(p + 1);
        end
        foreach (tbl[i]) begin
            @(negedge clk);
            s_tvalid = tbl[i].v; s_tlast = tbl[i].l; port_enable = tbl[i].en;
            m_tready = tbl[i].mr; cnt_clear = tbl[i].clr;
            #1;
            check($sformatf("tbl%0d_ctl", i), {m_tvalid, m_tlast, 5'(s_tready), cur_grant},
                  {tbl[i].e_mv, tbl[i].e_ml, tbl[i].e_sr, tbl[i].e_g});
            if (tbl[i].e_mv)
                check($sformatf("tbl%0d_data", i), {m_tuser, m_tkeep, m_tdata},
                      {16'h5500 + 16'(tbl[i].e_g), 4'(tbl[i].e_g + 1), 32'hD000_0000 + 32'(tbl[i].e_g)});
        end
        @(negedge clk); idle_inputs();
        check("tbl_cnt", {cnt_of(4)[7:0], cnt_of(3)[7:0], cnt_of(2)[7:0], cnt_of(1)[7:0], cnt_of(0)[7:0]},
              64'h01_00_01_00_00);

        // reset on beat 2 of a 5-beat packet
        do_reset();
        @(negedge clk); s_tvalid = 5'b00100; s_tlast = 5'b00000;
        @(negedge clk); #1; check("rst_beat0_ready", 64'(s_tready), 64'b00100);
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0; #1;
        check("rst_mid_pkt", {m_tvalid, 5'(s_tready), cur_grant}, 64'd0);
        check("rst_mid_cnt", 64'(pkt_cnt != '0), 64'd0);
        @(negedge clk); idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
